// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Three-state instruction sequencer (IDLE -> EXEC -> WB) that drives an
// external combinational ALU from an 8 x 32-bit register file and writes the
// result back.
//
// Ports
//   clk          single clock, all state updates on the rising edge
//   rst          synchronous, active-high reset
//   instr        16-bit instruction: [15:12] opcode, [11:9] rd, [8:6] rs1,
//                [5:3] rs2; LDI immediate is [8:0]
//   instr_valid  instr is presented (only looked at in IDLE)
//   instr_ready  high in IDLE only
//   op1, op2     operands to the external ALU (rf[rs1], rf[rs2] of instr_q)
//   alu_control  ALU operation select (instr_q opcode)
//   alu_result   ALU result for op1/op2/alu_control, same cycle
//   alu_zero     ALU zero flag for alu_result
//   done         one-cycle pulse after a register-file writeback
//   err          one-cycle pulse after an illegal opcode (9..15)
//   zero_flag    zero status of the last written result
//   wb_data      last value written to the register file
//   dbg_addr     debug read address
//   dbg_data     combinational read of rf[dbg_addr]
// -----------------------------------------------------------------------------
module alu_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [31:0] op1,
  output logic [31:0] op2,
  output logic [3:0]  alu_control,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        done,
  output logic        err,
  output logic        zero_flag,
  output logic [31:0] wb_data,
  input  logic [2:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam logic [3:0] OP_LDI = 4'd8;

  state_t      state_reg;
  logic [15:0] instr_q;
  logic [31:0] res_q;
  logic        zq;
  logic [31:0] rf [8];
  logic        done_reg;
  logic        err_reg;
  logic        zero_flag_reg;
  logic [31:0] wb_data_reg;

  // Field decode of the captured instruction
  logic [3:0] opcode;
  logic [2:0] rd;
  logic [2:0] rs1;
  logic [2:0] rs2;
  logic [8:0] imm;

  assign opcode = instr_q[15:12];
  assign rd     = instr_q[11:9];
  assign rs1    = instr_q[8:6];
  assign rs2    = instr_q[5:3];
  assign imm    = instr_q[8:0];

  // Per-entry write strobe: only the rd entry, only during WB
  logic [7:0] wr_en;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_wr_en
      assign wr_en[gi] = (state_reg == WB) && (rd == 3'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      instr_q       <= 16'd0;
      res_q         <= 32'd0;
      zq            <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      zero_flag_reg <= 1'b0;
      wb_data_reg   <= 32'd0;
      for (int i = 0; i < 8; i++) begin
        rf[i] <= 32'd0;
      end
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (instr_valid) begin
            instr_q   <= instr;
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          if (!opcode[3]) begin
            // Opcodes 0-7 go through the external ALU; operands were
            // read from rf here, before any writeback of this instruction.
            res_q     <= alu_result;
            zq        <= alu_zero;
            state_reg <= WB;
          end else if (opcode == OP_LDI) begin
            res_q     <= {23'd0, imm};
            zq        <= (imm == 9'd0);
            state_reg <= WB;
          end else begin
            // Illegal opcode: flag it and drop the instruction untouched
            err_reg   <= 1'b1;
            state_reg <= IDLE;
          end
        end
        WB: begin
          wb_data_reg   <= res_q;
          zero_flag_reg <= zq;
          done_reg      <= 1'b1;
          state_reg     <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
      for (int i = 0; i < 8; i++) begin
        if (wr_en[i]) begin
          rf[i] <= res_q;
        end
      end
    end
  end

  assign instr_ready = (state_reg == IDLE);
  assign op1         = rf[rs1];
  assign op2         = rf[rs2];
  assign alu_control = opcode;
  assign done        = done_reg;
  assign err         = err_reg;
  assign zero_flag   = zero_flag_reg;
  assign wb_data     = wb_data_reg;
  assign dbg_data    = rf[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
`timescale 1ns/100ps
// -----------------------------------------------------------------------------
// tb_alu_sequencer
//
// Table-driven bench for alu_sequencer plus hand-written sequences for
// back-to-back issue with instr_valid held high and reset during WB.
// The external ALU is modelled here as a combinational block.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        done;
  logic        err;
  logic        zero_flag;
  logic [31:0] wb_data;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .op1         (op1),
    .op2         (op2),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .done        (done),
    .err         (err),
    .zero_flag   (zero_flag),
    .wb_data     (wb_data),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // External ALU
  always_comb begin
    alu_result = 32'd0;
    case (alu_control)
      4'd0: alu_result = ~op1;
      4'd1: alu_result = op1 & op2;
      4'd2: alu_result = op1 ^ op2;
      4'd3: alu_result = op1 | op2;
      4'd4: alu_result = op1 - 32'd1;
      4'd5: alu_result = op1 + op2;
      4'd6: alu_result = op1 - op2;
      4'd7: alu_result = op1 + 32'd1;
      default: alu_result = 32'd0;
    endcase
  end
  assign alu_zero = (alu_result == 32'd0);

  typedef struct {
    logic [15:0] instr;
    logic        is_err;
    logic [31:0] val;
    logic        z;
  } vec_t;

  vec_t        vecs [20];
  logic [31:0] mrf [8];
  logic [31:0] exp_wb;
  logic        exp_z;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic logic [15:0] rr(input logic [3:0] op, input logic [2:0] d,
                                     input logic [2:0] s1, input logic [2:0] s2);
    return {op, d, s1, s2, 3'b000};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] d, input logic [8:0] imm);
    return {4'h8, d, imm};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rf_all(input string name);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #0.5;
      check(name, dbg_data, mrf[i]);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [2:0] d, s1, s2;
    d  = v.instr[11:9];
    s1 = v.instr[8:6];
    s2 = v.instr[5:3];
    check("ready_idle", 32'(instr_ready), 32'd1);
    instr       = v.instr;
    instr_valid = 1'b1;
    dbg_addr    = d;
    tick();                                   // accept edge N
    instr_valid = 1'b0;
    instr       = 16'h0000;
    check("ready_exec", 32'(instr_ready), 32'd0);
    check("alu_control", 32'(alu_control), 32'(v.instr[15:12]));
    if (!v.instr[15]) begin
      check("op1", op1, mrf[s1]);
      check("op2", op2, mrf[s2]);
    end
    tick();                                   // edge N+1
    if (v.is_err) begin
      check("err_pulse", 32'(err), 32'd1);
      check("err_no_done", 32'(done), 32'd0);
      check("err_ready", 32'(instr_ready), 32'd1);
      check("err_wb_kept", wb_data, exp_wb);
      check("err_zf_kept", 32'(zero_flag), 32'(exp_z));
      check("err_rf_kept", dbg_data, mrf[d]);
      tick();
      check("err_one_cycle", 32'(err), 32'd0);
      check("err_no_done2", 32'(done), 32'd0);
      $display("[TB] vec %0d instr=%h illegal, err pulsed", idx, v.instr);
    end else begin
      check("ready_wb", 32'(instr_ready), 32'd0);
      check("done_early", 32'(done), 32'd0);
      tick();                                 // edge N+2: writeback
      check("done_pulse", 32'(done), 32'd1);
      check("no_err", 32'(err), 32'd0);
      check("wb_data", wb_data, v.val);
      check("zero_flag", 32'(zero_flag), 32'(v.z));
      check("dbg_data", dbg_data, v.val);
      check("ready_after", 32'(instr_ready), 32'd1);
      mrf[d] = v.val;
      exp_wb = v.val;
      exp_z  = v.z;
      tick();
      check("done_one_cycle", 32'(done), 32'd0);
      $display("[TB] vec %0d instr=%h r%0d=%h z=%0d", idx, v.instr, d, wb_data, zero_flag);
    end
  endtask

  initial begin
    logic [15:0] seq_instr [3];
    logic [31:0] seq_val [3];

    // Hand-computed vectors, applied in order from an all-zero register file
    vecs[0]  = '{ldi(3'd1, 9'd5),         1'b0, 32'h0000_0005, 1'b0};
    vecs[1]  = '{ldi(3'd2, 9'd3),         1'b0, 32'h0000_0003, 1'b0};
    vecs[2]  = '{rr(4'd5, 3'd3, 3'd1, 3'd2), 1'b0, 32'h0000_0008, 1'b0};  // ADD
    vecs[3]  = '{ldi(3'd1, 9'd7),         1'b0, 32'h0000_0007, 1'b0};
    vecs[4]  = '{rr(4'd6, 3'd4, 3'd1, 3'd1), 1'b0, 32'h0000_0000, 1'b1};  // SUB
    vecs[5]  = '{ldi(3'd5, 9'h1FF),       1'b0, 32'h0000_01FF, 1'b0};
    vecs[6]  = '{rr(4'hA, 3'd5, 3'd1, 3'd2), 1'b1, 32'h0,        1'b0};  // illegal
    vecs[7]  = '{ldi(3'd1, 9'd0),         1'b0, 32'h0000_0000, 1'b1};
    vecs[8]  = '{rr(4'd4, 3'd1, 3'd1, 3'd0), 1'b0, 32'hFFFF_FFFF, 1'b0};  // DEC
    vecs[9]  = '{rr(4'd7, 3'd1, 3'd1, 3'd0), 1'b0, 32'h0000_0000, 1'b1};  // INC wrap
    vecs[10] = '{ldi(3'd6, 9'h0F0),       1'b0, 32'h0000_00F0, 1'b0};
    vecs[11] = '{ldi(3'd7, 9'h0FF),       1'b0, 32'h0000_00FF, 1'b0};
    vecs[12] = '{rr(4'd1, 3'd0, 3'd6, 3'd7), 1'b0, 32'h0000_00F0, 1'b0};  // AND -> r0
    vecs[13] = '{rr(4'd2, 3'd2, 3'd6, 3'd7), 1'b0, 32'h0000_000F, 1'b0};  // XOR
    vecs[14] = '{rr(4'd3, 3'd4, 3'd6, 3'd7), 1'b0, 32'h0000_00FF, 1'b0};  // OR
    vecs[15] = '{rr(4'd0, 3'd0, 3'd0, 3'd0), 1'b0, 32'hFFFF_FF0F, 1'b0};  // COMPLEMENT
    vecs[16] = '{ldi(3'd5, 9'd1),         1'b0, 32'h0000_0001, 1'b0};
    vecs[17] = '{rr(4'd4, 3'd2, 3'd1, 3'd0), 1'b0, 32'hFFFF_FFFF, 1'b0};  // DEC r1=0
    vecs[18] = '{rr(4'd5, 3'd3, 3'd2, 3'd5), 1'b0, 32'h0000_0000, 1'b1};  // ADD wrap
    vecs[19] = '{rr(4'hF, 3'd3, 3'd0, 3'd0), 1'b1, 32'h0,        1'b0};  // illegal

    for (int i = 0; i < 8; i++) mrf[i] = 32'd0;
    exp_wb = 32'd0;
    exp_z  = 1'b0;

    rst         = 1'b1;
    instr       = 16'h0000;
    instr_valid = 1'b0;
    dbg_addr    = 3'd0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_wb", wb_data, 32'd0);
    check("rst_zf", 32'(zero_flag), 32'd0);
    check_rf_all("rst_rf");
    tick();

    for (int i = 0; i < 20; i++) begin
      run_vec(i, vecs[i]);
    end
    check_rf_all("final_rf");
    tick();

    // instr_valid held high: one accept every 3 cycles
    seq_instr[0] = ldi(3'd1, 9'h011);
    seq_instr[1] = ldi(3'd2, 9'h022);
    seq_instr[2] = rr(4'd5, 3'd3, 3'd1, 3'd2);
    seq_val[0]   = 32'h11;
    seq_val[1]   = 32'h22;
    seq_val[2]   = 32'h33;
    instr_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("hold_ready_idle", 32'(instr_ready), 32'd1);
      instr = seq_instr[k];
      tick();
      check("hold_ready_exec", 32'(instr_ready), 32'd0);
      check("hold_no_done_exec", 32'(done), 32'd0);
      tick();
      check("hold_ready_wb", 32'(instr_ready), 32'd0);
      check("hold_no_done_wb", 32'(done), 32'd0);
      tick();
      check("hold_done", 32'(done), 32'd1);
      check("hold_wb", wb_data, seq_val[k]);
      $display("[TB] hold %0d instr=%h wb=%h", k, seq_instr[k], wb_data);
    end
    instr_valid = 1'b0;
    tick();
    check("hold_done_drop", 32'(done), 32'd0);

    // Reset while ADD r3 is in WB
    instr       = rr(4'd5, 3'd3, 3'd1, 3'd1);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    check("pre_rst_in_wb", 32'(instr_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) mrf[i] = 32'd0;
    exp_wb = 32'd0;
    exp_z  = 1'b0;
    check("wbrst_done", 32'(done), 32'd0);
    check("wbrst_err", 32'(err), 32'd0);
    check("wbrst_ready", 32'(instr_ready), 32'd1);
    check("wbrst_wb", wb_data, 32'd0);
    check("wbrst_zf", 32'(zero_flag), 32'd0);
    check("wbrst_ctrl", 32'(alu_control), 32'd0);
    check("wbrst_op1", op1, 32'd0);
    check_rf_all("wbrst_rf");
    $display("[TB] reset during WB: r3=%h done=%0d", mrf[3], done);
    tick();
    check("wbrst_no_late_done", 32'(done), 32'd0);
    check("wbrst_ready2", 32'(instr_ready), 32'd1);

    // Recovery after reset
    begin
      vec_t v;
      v = '{ldi(3'd3, 9'h1AB), 1'b0, 32'h0000_01AB, 1'b0};
      run_vec(20, v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The module SHALL have no parameters; data width is 32 bits, register file is 8 x 32 bits, and the instruction word is 16 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 instr  input  16  instruction word: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [2:0] ignored; LDI immediate = [8:0].
REQ-005 instr_valid  input  1  instr is presented.
REQ-006 instr_ready  output  1  sequencer can accept an instruction.
REQ-007 op1, op2  output  32 each  operands to the external combinational ALU.
REQ-008 alu_control  output  4  ALU operation select.
REQ-009 alu_result  input  32  ALU result, valid in the same cycle as op1/op2/alu_control.
REQ-010 alu_zero  input  1  ALU zero flag for alu_result.
REQ-011 done  output  1  one-cycle pulse on register-file writeback.
REQ-012 err  output  1  one-cycle pulse on an illegal opcode.
REQ-013 zero_flag  output  1  zero status of the last written result.
REQ-014 wb_data  output  32  last value written to the register file.
REQ-015 dbg_addr  input  3  debug register-file read address.
REQ-016 dbg_data  output  32  combinational read of rf[dbg_addr].

Function
REQ-017 The FSM SHALL have states IDLE, EXEC and WB, with instr_ready=1 only in IDLE.
REQ-018 In IDLE, when instr_valid=1, the module SHALL capture instr into instr_q and go to EXEC; otherwise it SHALL stay in IDLE.
REQ-019 op1=rf[instr_q rs1], op2=rf[instr_q rs2] and alu_control=instr_q[15:12] SHALL be driven combinationally from instr_q in all states.
REQ-020 In EXEC, opcodes 0-7 (COMPLEMENT, AND, XOR, OR, DECREMENT, ADD, SUB, INCREMENT) SHALL register res_q<=alu_result and zq<=alu_zero, then go to WB.
REQ-021 In EXEC, opcode 8 (LDI) SHALL register res_q<={23'b0, instr_q[8:0]} and zq<=(immediate==0), ignore the ALU, then go to WB.
REQ-022 In EXEC, opcodes 9-15 SHALL pulse err for one cycle (registered, high in the cycle after EXEC), go to IDLE, and leave rf, wb_data and zero_flag unchanged.
REQ-023 In WB, the module SHALL write rf[rd]<=res_q, wb_data<=res_q and zero_flag<=zq, pulse done for one cycle (high in the cycle after WB), then go to IDLE.
REQ-024 Latency: for an instruction accepted at edge N, the write SHALL be visible and done=1 after edge N+2; the next accept SHALL be possible at edge N+3.
REQ-025 All 8 registers SHALL be writable, including r0; rd may equal rs1 or rs2, because operands are sampled in EXEC before the WB write.
REQ-026 All ALU arithmetic SHALL be modulo 2^32, so 0xFFFFFFFF+1 gives 0 with zero_flag=1.
REQ-027 instr_valid SHALL be ignored in EXEC and WB, with no queueing; the upstream holds instr until instr_ready=1.
REQ-028 dbg_data SHALL reflect a WB write from the cycle after the writing edge.

Reset
REQ-029 When rst=1 at a clock edge, the module SHALL force state=IDLE, instr_q=0, res_q=0, zq=0, all rf entries=0, wb_data=0, zero_flag=0, done=0 and err=0.
REQ-030 Reset SHALL take priority in any state; an instruction in EXEC or WB SHALL be abandoned with no rf write and no done pulse.
REQ-031 instr_ready SHALL be 1 in the first cycle after reset is released.

Verification
REQ-032 LDI r1,5 then LDI r2,3 then ADD r3,r1,r2 -> rf[3]=8, done pulses, zero_flag=0, wb_data=8.
REQ-033 LDI r1,7 then SUB r4,r1,r1 -> rf[4]=0 and zero_flag=1; then LDI r5,0x1FF -> zero_flag=0, rf[5]=0x000001FF.
REQ-034 LDI r1,0 then DECREMENT r1 -> r1=0xFFFFFFFF; then INCREMENT r1 -> r1=0 and zero_flag=1 (wrap-around).
REQ-035 opcode 0xA presented -> err pulses one cycle, no done, all rf entries unchanged, and instr_ready=1 again two cycles after accept.
REQ-036 Hold instr_valid=1 continuously with 3 distinct instructions -> exactly one accept per 3 cycles and instr_ready=0 during EXEC and WB.
REQ-037 Assert rst during the WB of ADD r3 -> rf[3]=0, no done pulse, all outputs at reset values, instr_ready=1 after release.
